mem_stage_lsu: RTL

Memory-stage load/store unit between EX/MEM and MEM/WB.
- Takes the EX-stage result and control bits.
- Runs a valid/ready request and valid response handshake to data memory, stalling the pipeline while an access is outstanding.
- Registers the MEM/WB bundle (ALU result, load data, PC, jump, memToReg) consumed by the writeback select mux.

---
 rtl/mem_stage_lsu.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit between EX/MEM and MEM/WB
//
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   ex_*                        EX/MEM bundle: result/address, store data, PC, rd and control bits
//   mem_stall                   holds EX/MEM and upstream while a data-memory access is in flight
//   dmem_req_* / dmem_addr /    valid/ready request channel (word-aligned address)
//   dmem_wdata
//   dmem_rsp_valid/_rdata       read response channel (no backpressure)
//   wb_*                        registered MEM/WB bundle, wb_valid pulses once per retired instruction
//   timeout_err                 sticky flag: a read was force-completed without a response
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_ALU_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_PC,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regWrite,
    input  logic        ex_memRead,
    input  logic        ex_memWrite,
    input  logic        ex_memToReg,
    input  logic        ex_jump,
    output logic        mem_stall,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_ALU_result,
    output logic [31:0] wb_dmem_read_data,
    output logic [31:0] wb_PC,
    output logic [4:0]  wb_rd,
    output logic        wb_regWrite,
    output logic        wb_memToReg,
    output logic        wb_jump,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REQ      = 2'd1,
        S_WAIT_RSP = 2'd2
    } state_t;

    // Counter value seen in the last permitted WAIT_RSP cycle: the counter is
    // cleared on entry, so this gives exactly TIMEOUT_CYCLES waiting cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] hold_alu_q, hold_alu_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic        hold_regwrite_q, hold_regwrite_d;
    logic        hold_memtoreg_q, hold_memtoreg_d;
    logic        hold_we_q, hold_we_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        wb_memtoreg_q, wb_memtoreg_d;
    logic        wb_jump_q, wb_jump_d;
    logic        timeout_err_q, timeout_err_d;

    logic        mem_op;
    logic        complete;
    logic [31:0] complete_rdata;

    // Jump wins over memRead/memWrite: a JAL never touches data memory.
    assign mem_op = !ex_jump && (ex_memRead || ex_memWrite);

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hold_alu_d      = hold_alu_q;
        hold_wdata_d    = hold_wdata_q;
        hold_pc_d       = hold_pc_q;
        hold_rd_d       = hold_rd_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_memtoreg_d = hold_memtoreg_q;
        hold_we_d       = hold_we_q;
        wb_valid_d      = 1'b0;
        wb_alu_d        = wb_alu_q;
        wb_rdata_d      = wb_rdata_q;
        wb_pc_d         = wb_pc_q;
        wb_rd_d         = wb_rd_q;
        wb_regwrite_d   = wb_regwrite_q;
        wb_memtoreg_d   = wb_memtoreg_q;
        wb_jump_d       = wb_jump_q;
        timeout_err_d   = timeout_err_q;
        mem_stall       = 1'b0;
        dmem_req_valid  = 1'b0;
        complete        = 1'b0;
        complete_rdata  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    if (mem_op) begin
                        hold_alu_d      = ex_ALU_result;
                        hold_wdata_d    = ex_store_data;
                        hold_pc_d       = ex_PC;
                        hold_rd_d       = ex_rd;
                        hold_regwrite_d = ex_regWrite;
                        hold_memtoreg_d = ex_memToReg;
                        // Read+write together is treated as a plain read.
                        hold_we_d       = ex_memWrite && !ex_memRead;
                        mem_stall       = 1'b1;
                        state_d         = S_REQ;
                    end else begin
                        wb_valid_d    = 1'b1;
                        wb_alu_d      = ex_ALU_result;
                        wb_rdata_d    = 32'd0;
                        wb_pc_d       = ex_PC;
                        wb_rd_d       = ex_rd;
                        wb_regwrite_d = ex_regWrite;
                        wb_memtoreg_d = ex_memToReg;
                        wb_jump_d     = ex_jump;
                    end
                end
            end
            S_REQ: begin
                dmem_req_valid = 1'b1;
                mem_stall      = 1'b1;
                if (dmem_req_ready) begin
                    if (hold_we_q) begin
                        complete = 1'b1;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT_RSP;
                    end
                end
            end
            S_WAIT_RSP: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                // A response in the limit cycle beats the timeout.
                if (dmem_rsp_valid) begin
                    complete       = 1'b1;
                    complete_rdata = dmem_rsp_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    complete      = 1'b1;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The completion cycle drops the stall so upstream advances on the
        // same edge that loads MEM/WB.
        if (complete) begin
            mem_stall     = 1'b0;
            state_d       = S_IDLE;
            wb_valid_d    = 1'b1;
            wb_alu_d      = hold_alu_q;
            wb_rdata_d    = complete_rdata;
            wb_pc_d       = hold_pc_q;
            wb_rd_d       = hold_rd_q;
            wb_regwrite_d = hold_regwrite_q;
            wb_memtoreg_d = hold_memtoreg_q;
            wb_jump_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= 8'd0;
            hold_alu_q      <= 32'd0;
            hold_wdata_q    <= 32'd0;
            hold_pc_q       <= 32'd0;
            hold_rd_q       <= 5'd0;
            hold_regwrite_q <= 1'b0;
            hold_memtoreg_q <= 1'b0;
            hold_we_q       <= 1'b0;
            wb_valid_q      <= 1'b0;
            wb_alu_q        <= 32'd0;
            wb_rdata_q      <= 32'd0;
            wb_pc_q         <= 32'd0;
            wb_rd_q         <= 5'd0;
            wb_regwrite_q   <= 1'b0;
            wb_memtoreg_q   <= 1'b0;
            wb_jump_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hold_alu_q      <= hold_alu_d;
            hold_wdata_q    <= hold_wdata_d;
            hold_pc_q       <= hold_pc_d;
            hold_rd_q       <= hold_rd_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_memtoreg_q <= hold_memtoreg_d;
            hold_we_q       <= hold_we_d;
            wb_valid_q      <= wb_valid_d;
            wb_alu_q        <= wb_alu_d;
            wb_rdata_q      <= wb_rdata_d;
            wb_pc_q         <= wb_pc_d;
            wb_rd_q         <= wb_rd_d;
            wb_regwrite_q   <= wb_regwrite_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_jump_q       <= wb_jump_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign dmem_req_we       = hold_we_q;
    assign dmem_addr         = {hold_alu_q[31:2], 2'b00};
    assign dmem_wdata        = hold_wdata_q;
    assign wb_valid          = wb_valid_q;
    assign wb_ALU_result     = wb_alu_q;
    assign wb_dmem_read_data = wb_rdata_q;
    assign wb_PC             = wb_pc_q;
    assign wb_rd             = wb_rd_q;
    assign wb_regWrite       = wb_regwrite_q;
    assign wb_memToReg       = wb_memtoreg_q;
    assign wb_jump           = wb_jump_q;
    assign timeout_err       = timeout_err_q;

endmodule
